// File: rtl/up_axi_pkg.sv
// Shared definitions for the up_* to AXI4-Lite initiator: response codes,
// sequencer states and the read data returned on an aborted read.
package up_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE_W,
    DONE_R
  } up_axi_state_t;

endpackage

// File: rtl/up_axi_master_if.sv
// AXI4-Lite bus bundle; master drives address/data/valids and the response readies.
interface up_axi_master_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/up_axi_master_timeout.sv
// Per-transaction watchdog: cleared while idle, counts enabled cycles and flags the
// last allowed cycle combinationally; TIMEOUT_CYCLES of 0 never expires.
module up_axi_master_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic up_clk,
  input  logic up_rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted during the TIMEOUT_CYCLES-th busy cycle so the abort lands right after it.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

endmodule

// File: rtl/up_axi_master.sv
// up_* register-bus requests to single AXI4-Lite transactions, one in flight at a time.
// Request-to-valid 2 cycles; one pending slot per direction, overflow is dropped and flagged.
module up_axi_master
  import up_axi_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 14,
  parameter logic [31:0] AXI_BASE       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     up_wreq,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  output logic                     up_werr,
  input  logic                     up_rreq,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  output logic                     up_rerr,
  output logic                     up_busy,
  output logic                     up_drop,
  up_axi_master_if.master          m_axi
);

  up_axi_state_t              state;
  logic                       wslot_vld;
  logic [ADDRESS_WIDTH-1:0]   wslot_addr;
  logic [31:0]                wslot_dat;
  logic                       rslot_vld;
  logic [ADDRESS_WIDTH-1:0]   rslot_addr;
  logic                       tmo_en;
  logic                       tmo_expired;
  logic                       aw_open;
  logic                       w_open;

  // Slots hold the request until DONE, so address/data are stable while valid.
  assign m_axi.awaddr = AXI_BASE | 32'({wslot_addr, 2'b00});
  assign m_axi.araddr = AXI_BASE | 32'({rslot_addr, 2'b00});
  assign m_axi.wdata  = wslot_dat;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = 4'hF;

  assign up_busy = (state != IDLE) | wslot_vld | rslot_vld;
  assign tmo_en  = (state == WR) | (state == WR_RESP) | (state == RD) | (state == RD_RESP);
  assign aw_open = m_axi.awvalid & ~m_axi.awready;
  assign w_open  = m_axi.wvalid & ~m_axi.wready;

  up_axi_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .clr     (state == IDLE),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state         <= IDLE;
      wslot_vld     <= 1'b0;
      wslot_addr    <= '0;
      wslot_dat     <= '0;
      rslot_vld     <= 1'b0;
      rslot_addr    <= '0;
      up_drop       <= 1'b0;
      up_wack       <= 1'b0;
      up_werr       <= 1'b0;
      up_rack       <= 1'b0;
      up_rerr       <= 1'b0;
      up_rdata      <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      // A slot being released in DONE can accept a new request in the same cycle.
      if (up_wreq) begin
        if (!wslot_vld || state == DONE_W) begin
          wslot_vld  <= 1'b1;
          wslot_addr <= up_waddr;
          wslot_dat  <= up_wdata;
        end else begin
          up_drop <= 1'b1;
        end
      end else if (state == DONE_W) begin
        wslot_vld <= 1'b0;
      end

      if (up_rreq) begin
        if (!rslot_vld || state == DONE_R) begin
          rslot_vld  <= 1'b1;
          rslot_addr <= up_raddr;
        end else begin
          up_drop <= 1'b1;
        end
      end else if (state == DONE_R) begin
        rslot_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wslot_vld) begin
            state         <= WR;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
          end else if (rslot_vld) begin
            state         <= RD;
            m_axi.arvalid <= 1'b1;
          end
        end
        WR: begin
          if (tmo_expired) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            up_werr       <= 1'b1;
            up_wack       <= 1'b1;
            state         <= DONE_W;
          end else begin
            if (m_axi.awready) m_axi.awvalid <= 1'b0;
            if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
            if (!aw_open && !w_open) begin
              m_axi.bready <= 1'b1;
              state        <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (tmo_expired || m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            up_werr      <= tmo_expired || (m_axi.bresp != AXI_RESP_OKAY);
            up_wack      <= 1'b1;
            state        <= DONE_W;
          end
        end
        RD: begin
          if (tmo_expired) begin
            m_axi.arvalid <= 1'b0;
            up_rerr       <= 1'b1;
            up_rack       <= 1'b1;
            up_rdata      <= TIMEOUT_RDATA;
            state         <= DONE_R;
          end else if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (tmo_expired || m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            up_rerr      <= tmo_expired || (m_axi.rresp != AXI_RESP_OKAY);
            up_rdata     <= tmo_expired ? TIMEOUT_RDATA : m_axi.rdata;
            up_rack      <= 1'b1;
            state        <= DONE_R;
          end
        end
        DONE_W: begin
          up_wack <= 1'b0;
          up_werr <= 1'b0;
          state   <= IDLE;
        end
        DONE_R: begin
          up_rack  <= 1'b0;
          up_rerr  <= 1'b0;
          up_rdata <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_axi_master.sv
// Scoreboard bench for up_axi_master: directed requests push expected AXI beats and
// up_* responses; slave models and a response monitor pop and compare.
module tb_up_axi_master;
  import up_axi_pkg::*;

  logic        up_clk = 1'b0;
  logic        up_rstn = 1'b0;
  logic        up_wreq = 1'b0;
  logic [13:0] up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_werr;
  logic        up_rreq = 1'b0;
  logic [13:0] up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        up_rerr;
  logic        up_busy;
  logic        up_drop;

  up_axi_master_if m_axi();

  up_axi_master #(
    .ADDRESS_WIDTH (14),
    .AXI_BASE      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .up_wreq (up_wreq),
    .up_waddr(up_waddr),
    .up_wdata(up_wdata),
    .up_wack (up_wack),
    .up_werr (up_werr),
    .up_rreq (up_rreq),
    .up_raddr(up_raddr),
    .up_rdata(up_rdata),
    .up_rack (up_rack),
    .up_rerr (up_rerr),
    .up_busy (up_busy),
    .up_drop (up_drop),
    .m_axi   (m_axi)
  );

  always #5 up_clk = ~up_clk;

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] exp_awaddr[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] exp_araddr[$];

  int errors = 0;
  int checks = 0;

  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          r_never = 1'b0;
  logic [1:0]  bresp_v = 2'b00;
  logic [1:0]  rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, expected one", name);
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return m_axi.awvalid;
      1:       return m_axi.bready;
      2:       return m_axi.arvalid;
      3:       return up_rack;
      4:       return up_wack;
      default: return up_busy;
    endcase
  endfunction

  task automatic wait_until(input int which, input bit level, input int max, input string name,
                            output int n);
    n = 0;
    while (n < max) begin
      @(negedge up_clk);
      n++;
      if (sig(which) == level) return;
    end
    fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    wait_until(5, 1'b0, 200, name, n);
    chk({name, "_resp_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_axi_left"}, 32'(exp_awaddr.size() + exp_wdata.size() + exp_araddr.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid,
                              m_axi.rready, up_wack, up_werr, up_rack, up_rerr, up_busy,
                              up_drop}), 32'd0);
    chk({name, "_rdata"}, up_rdata, 32'd0);
  endtask

  // Caller positions on a negedge; the request is held for one rising edge.
  task automatic issue_w(input logic [13:0] a, input logic [31:0] d, input logic [31:0] exp_addr,
                         input bit exp_err, input bit expect_it);
    up_wreq  = 1'b1;
    up_waddr = a;
    up_wdata = d;
    if (expect_it) begin
      exp_q.push_back(resp_t'{is_rd: 1'b0, err: exp_err, rdata: 32'h0});
      exp_awaddr.push_back(exp_addr);
      exp_wdata.push_back(d);
    end
    @(negedge up_clk);
    up_wreq = 1'b0;
  endtask

  task automatic issue_r(input logic [13:0] a, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                         input bit exp_err);
    up_rreq  = 1'b1;
    up_raddr = a;
    exp_q.push_back(resp_t'{is_rd: 1'b1, err: exp_err, rdata: exp_data});
    exp_araddr.push_back(exp_addr);
    @(negedge up_clk);
    up_rreq = 1'b0;
  endtask

  // AXI-Lite slave channel models: drive on negedge, DUT samples at the next posedge.
  initial begin
    int cnt = 0;
    m_axi.awready = 1'b0;
    forever begin
      @(negedge up_clk);
      if (!up_rstn) begin
        m_axi.awready = 1'b0;
        cnt = 0;
      end else if (m_axi.awready) begin
        m_axi.awready = 1'b0;
      end else if (m_axi.awvalid) begin
        if (cnt >= aw_dly) begin
          m_axi.awready = 1'b1;
          cnt = 0;
          if (exp_awaddr.size() == 0) fail("unexpected_aw");
          else chk("awaddr", m_axi.awaddr, exp_awaddr.pop_front());
          chk("awprot", 32'(m_axi.awprot), 32'd0);
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    m_axi.wready = 1'b0;
    forever begin
      @(negedge up_clk);
      if (!up_rstn) begin
        m_axi.wready = 1'b0;
        cnt = 0;
      end else if (m_axi.wready) begin
        m_axi.wready = 1'b0;
      end else if (m_axi.wvalid) begin
        if (cnt >= w_dly) begin
          m_axi.wready = 1'b1;
          cnt = 0;
          if (exp_wdata.size() == 0) fail("unexpected_w");
          else chk("wdata", m_axi.wdata, exp_wdata.pop_front());
          chk("wstrb", 32'(m_axi.wstrb), 32'hF);
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
    forever begin
      @(negedge up_clk);
      if (!up_rstn || m_axi.bvalid) begin
        m_axi.bvalid = 1'b0;
        cnt = 0;
      end else if (m_axi.bready) begin
        if (cnt >= b_dly) begin
          m_axi.bvalid = 1'b1;
          m_axi.bresp  = bresp_v;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    m_axi.arready = 1'b0;
    forever begin
      @(negedge up_clk);
      if (!up_rstn) begin
        m_axi.arready = 1'b0;
        cnt = 0;
      end else if (m_axi.arready) begin
        m_axi.arready = 1'b0;
      end else if (m_axi.arvalid) begin
        if (cnt >= ar_dly) begin
          m_axi.arready = 1'b1;
          cnt = 0;
          if (exp_araddr.size() == 0) fail("unexpected_ar");
          else chk("araddr", m_axi.araddr, exp_araddr.pop_front());
          chk("arprot", 32'(m_axi.arprot), 32'd0);
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    m_axi.rvalid = 1'b0;
    m_axi.rdata  = '0;
    m_axi.rresp  = 2'b00;
    forever begin
      @(negedge up_clk);
      if (!up_rstn || m_axi.rvalid) begin
        m_axi.rvalid = 1'b0;
        cnt = 0;
      end else if (m_axi.rready && !r_never) begin
        if (cnt >= r_dly) begin
          m_axi.rvalid = 1'b1;
          m_axi.rdata  = rdata_v;
          m_axi.rresp  = rresp_v;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // Response monitor: every ack pops the oldest expected response.
  initial begin
    bit    rack_prev = 1'b0;
    resp_t e;
    forever begin
      @(negedge up_clk);
      if (!up_rstn) begin
        rack_prev = 1'b0;
      end else begin
        if (rack_prev) chk("rdata_after_rack", up_rdata, 32'd0);
        if (up_wack || up_rack) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_ack");
          end else begin
            e = exp_q.pop_front();
            chk("ack_kind", 32'({up_wack, up_rack}), e.is_rd ? 32'd1 : 32'd2);
            if (e.is_rd) begin
              chk("rerr", 32'(up_rerr), 32'(e.err));
              chk("rdata", up_rdata, e.rdata);
            end else begin
              chk("werr", 32'(up_werr), 32'(e.err));
            end
          end
        end
        rack_prev = up_rack;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge up_clk);
    chk_all_zero("reset");
    up_rstn = 1'b1;
    @(negedge up_clk);

    // Single write, zero-latency slave; request presented at this negedge.
    issue_w(14'h0010, 32'h1234_5678, 32'h0000_0040, 1'b0, 1'b1);
    chk("wr_valid_early", 32'(m_axi.awvalid), 32'd0);
    wait_until(0, 1'b1, 5, "wr_awvalid", n);
    chk("wr_latency", 32'(n), 32'd1);
    wait_idle("wr_basic");

    // Read with response delayed by 5 cycles.
    r_dly   = 5;
    rdata_v = 32'hCAFE_0001;
    @(negedge up_clk);
    issue_r(14'h0003, 32'h0000_000C, 32'hCAFE_0001, 1'b0);
    wait_idle("rd_delay");
    r_dly = 0;

    // Split write handshakes with an error response.
    aw_dly  = 1;
    w_dly   = 4;
    bresp_v = AXI_RESP_SLVERR;
    @(negedge up_clk);
    issue_w(14'h0100, 32'hA5A5_0F0F, 32'h0000_0400, 1'b1, 1'b1);
    wait_until(0, 1'b1, 5, "split_awvalid", n);
    wait_until(0, 1'b0, 10, "split_aw_drop", n);
    chk("split_w_still_valid", 32'(m_axi.wvalid), 32'd1);
    chk("split_bready_early", 32'(m_axi.bready), 32'd0);
    wait_until(1, 1'b1, 10, "split_bready", n);
    chk("split_w_done", 32'({m_axi.awvalid, m_axi.wvalid}), 32'd0);
    wait_idle("wr_split");
    aw_dly  = 0;
    w_dly   = 0;
    bresp_v = AXI_RESP_OKAY;

    // Simultaneous write and read: write first, busy until both complete.
    rdata_v = 32'h5555_AAAA;
    @(negedge up_clk);
    up_wreq  = 1'b1;
    up_waddr = 14'h0020;
    up_wdata = 32'h0BAD_F00D;
    up_rreq  = 1'b1;
    up_raddr = 14'h0021;
    exp_q.push_back(resp_t'{is_rd: 1'b0, err: 1'b0, rdata: 32'h0});
    exp_awaddr.push_back(32'h0000_0080);
    exp_wdata.push_back(32'h0BAD_F00D);
    exp_q.push_back(resp_t'{is_rd: 1'b1, err: 1'b0, rdata: 32'h5555_AAAA});
    exp_araddr.push_back(32'h0000_0084);
    @(negedge up_clk);
    up_wreq = 1'b0;
    up_rreq = 1'b0;
    chk("both_busy", 32'(up_busy), 32'd1);
    wait_idle("wr_rd_pair");
    chk("pair_no_drop", 32'(up_drop), 32'd0);

    // A write arriving in the DONE_W cycle is captured, not dropped.
    @(negedge up_clk);
    issue_w(14'h0040, 32'h0101_0202, 32'h0000_0100, 1'b0, 1'b1);
    wait_until(4, 1'b1, 20, "b2b_wack", n);
    issue_w(14'h0041, 32'h0303_0404, 32'h0000_0104, 1'b0, 1'b1);
    wait_idle("wr_b2b");
    chk("b2b_no_drop", 32'(up_drop), 32'd0);

    // Second write while the first is in flight is dropped; drop is sticky.
    aw_dly = 3;
    @(negedge up_clk);
    issue_w(14'h0030, 32'h1111_2222, 32'h0000_00C0, 1'b0, 1'b1);
    wait_until(0, 1'b1, 5, "drop_awvalid", n);
    issue_w(14'h0031, 32'h3333_4444, 32'h0000_00C4, 1'b0, 1'b0);
    chk("drop_set", 32'(up_drop), 32'd1);
    wait_idle("wr_drop");
    chk("drop_sticky", 32'(up_drop), 32'd1);
    aw_dly = 0;

    // Read timeout: slave never returns rvalid.
    r_never = 1'b1;
    @(negedge up_clk);
    issue_r(14'h0005, 32'h0000_0014, TIMEOUT_RDATA, 1'b1);
    wait_until(2, 1'b1, 5, "tmo_arvalid", n);
    wait_until(3, 1'b1, 40, "tmo_rack", n);
    chk("tmo_cycles", 32'(n), 32'd16);
    wait_idle("rd_timeout");
    r_never = 1'b0;

    // Asynchronous reset in the middle of a write.
    aw_dly = 10;
    @(negedge up_clk);
    issue_w(14'h0050, 32'h7777_8888, 32'h0000_0140, 1'b0, 1'b1);
    wait_until(0, 1'b1, 5, "rst_awvalid", n);
    #2 up_rstn = 1'b0;
    #1 chk_all_zero("rst_mid");
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    exp_q.delete();
    exp_awaddr.delete();
    exp_wdata.delete();
    aw_dly = 0;
    @(negedge up_clk);
    up_rstn = 1'b1;
    @(negedge up_clk);
    issue_w(14'h0002, 32'hFFFF_0000, 32'h0000_0008, 1'b0, 1'b1);
    wait_idle("wr_after_rst");
    chk("drop_after_rst", 32'(up_drop), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_axi_master.md
Name: up_axi_master

Overview:
- AXI4-Lite initiator that converts the internal up_* register-bus request pulses (wreq/waddr/wdata, rreq/raddr) into single AXI4-Lite write and read transactions.
- Returns wack/rack/rdata pulses with the same timing contract as the cores' up_* register bus.
- Sits in the up_clk domain. A local sequencer or control block uses it to program a remote AXI-Lite peripheral, e.g. another core's register map.
- Handles one outstanding transaction at a time, with a per-transaction response timeout.

Parameters:
- ADDRESS_WIDTH, 14, width of the up_* word address.
- AXI_BASE, 32'h0000_0000, byte base ORed into every AXI address.
- TIMEOUT_CYCLES, 1023, up_clk cycles allowed per transaction before forced completion with error; 0 disables the timeout.

Ports:
- up_clk  in  1  clock
- up_rstn  in  1  reset
- up_wreq  in  1  write request pulse
- up_waddr  in  ADDRESS_WIDTH  write word address
- up_wdata  in  32  write data
- up_wack  out  1  write done pulse
- up_werr  out  1  write error, valid with up_wack
- up_rreq  in  1  read request pulse
- up_raddr  in  ADDRESS_WIDTH  read word address
- up_rdata  out  32  read data, valid with up_rack, else 0
- up_rack  out  1  read done pulse
- up_rerr  out  1  read error, valid with up_rack
- up_busy  out  1  transaction in flight or pending
- up_drop  out  1  sticky: request lost; cleared by reset only
- m_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI write address channel
- m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  AXI write data channel
- m_axi_bvalid/bready/bresp[1:0]  AXI write response channel
- m_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  AXI read address channel
- m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]  AXI read data channel

Behaviour:
- Reset: up_rstn asynchronous, active-low; clock up_clk. All outputs reset to 0: valids, readies, ack, err, rdata, busy, drop, pending slots. State is IDLE.
- Constant outputs:
  - awprot = arprot = 3'b000
  - wstrb = 4'hF
  - awaddr = AXI_BASE | {waddr, 2'b00}, zero-extended to 32 bits; araddr formed the same way from raddr.
- Request capture:
  - One pending write slot (addr, data) and one pending read slot (addr).
  - A wreq fills the write slot if it is empty; otherwise the request is discarded and up_drop is set. rreq behaves the same way with the read slot.
- FSM states and transitions:
  - IDLE: a pending write starts WR and has priority over a pending read; otherwise a pending read starts RD. A slot captured this cycle is launched next cycle, so request-to-awvalid/arvalid is 2 cycles.
  - WR: awvalid and wvalid rise together. Each drops independently on its own ready handshake. When both handshakes are done, go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, go to DONE_W with werr = (bresp != 2'b00).
  - RD: arvalid=1 until arready, then go to RD_RESP.
  - RD_RESP: rready=1. On rvalid, latch rdata and go to DONE_R with rerr = (rresp != 2'b00).
  - DONE_W: up_wack=1 for 1 cycle, clear the write slot, return to IDLE.
  - DONE_R: up_rack=1 and up_rdata valid for 1 cycle, clear the read slot, return to IDLE. up_rdata returns to 0 on the next cycle.
- Timeout:
  - A counter starts at 0 on leaving IDLE and counts every busy cycle.
  - On reaching TIMEOUT_CYCLES: deassert all valids and readies, go to DONE_W or DONE_R with err=1. For a read, up_rdata = 32'hDEAD_DEAD.
  - A late bvalid or rvalid after timeout is ignored: bready and rready are 0 in IDLE.
- Simultaneous wreq and rreq in one cycle: both captured; write executes first, read immediately after.
- A request arriving in the same cycle its slot clears (DONE) is captured, not dropped.
- up_busy = (state != IDLE) | any slot full.
- AXI compliance: a valid is never dropped before its handshake, except on timeout abort. Address and data stay stable while valid.

Decomposition:
- Shared package up_axi_pkg:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - FSM state enum (IDLE, WR, WR_RESP, RD, RD_RESP, DONE_W, DONE_R)
  - TIMEOUT_RDATA constant 32'hDEAD_DEAD
- One natural sub-module: up_axi_master_timeout (load/enable counter with expiry flag). Everything else is in the top.

Test Plan:
- Write, zero-latency slave: waddr=14'h0010, wdata=32'h1234_5678 → awaddr=32'h0000_0040, wdata matches, wstrb=F. bresp=OKAY → single up_wack pulse with up_werr=0.
- Read, slave with rvalid delayed 5 cycles: raddr=14'h0003, rdata=32'hCAFE_0001 → araddr=32'h0000_000C. up_rack pulse with up_rdata=32'hCAFE_0001 for exactly 1 cycle, 0 afterwards.
- Split handshakes, awready at +1 and wready at +4: each valid drops only after its own handshake; bready asserts after both. bresp=SLVERR → up_werr=1.
- Simultaneous wreq and rreq: write completes first (wack), then read (rack). No drop. up_busy is high throughout, then 0.
- Second wreq while a write is pending and in flight → up_drop=1 sticky; only the first write appears on the AXI bus.
- TIMEOUT_CYCLES=16, slave never asserts rvalid → rack at +16 busy cycles with rerr=1 and rdata=32'hDEAD_DEAD. Then assert up_rstn=0 mid-write → all outputs 0 immediately, FSM in IDLE.
